// File: rtl/tlp_cmp_gen.sv
// Completion generator: queues MRd requests, reads one DW from a register file and emits
// a 2-beat CplD on a 64-bit Avalon-ST TX port. Define TLP_CMP_GEN_UR_EN for UR completions.
module tlp_cmp_gen #(
    parameter int REG_ABITS  = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 pcieClk_in,
    input  logic                 pcieRst_in,
    input  logic [15:0]          cmpID_in,
    input  logic                 req_valid_in,
    output logic                 req_ready_out,
    input  logic [15:0]          req_reqID_in,
    input  logic [7:0]           req_tag_in,
    input  logic [29:0]          req_addr_in,
    output logic [REG_ABITS-1:0] regRdAddr_out,
    input  logic [31:0]          regRdData_in,
    output logic [63:0]          tx_data_out,
    output logic                 tx_valid_out,
    input  logic                 tx_ready_in,
    output logic                 tx_sop_out,
    output logic                 tx_eop_out
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [15:0] req_id;
        logic [7:0]  tag;
        logic [29:0] addr;
    } req_t;

    typedef enum logic [2:0] {StIdle, StRead, StLatch, StHdr, StData} state_t;

    req_t            mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            full, empty, push, pop, head_ur;
    req_t            head, hold;
    logic [31:0]     data_q;
    state_t          state;
    logic            unused_addr;

    assign full          = (count == CW'(FIFO_DEPTH));
    assign empty         = (count == '0);
    assign req_ready_out = !full && !pcieRst_in;
    assign push          = req_valid_in && req_ready_out;
    assign head          = mem[rd_ptr];
    assign regRdAddr_out = hold.addr[REG_ABITS-1:0];
    assign unused_addr   = ^hold.addr;

    // Pop whenever the FSM is free to start the next completion.
    always_comb begin
        pop = 1'b0;
        if (!empty) begin
            if (state == StIdle) pop = 1'b1;
            else if (state == StData && tx_ready_in) pop = 1'b1;
        end
    end

`ifdef TLP_CMP_GEN_UR_EN
    assign head_ur = |head.addr[29:REG_ABITS];
`else
    assign head_ur = 1'b0;
`endif

    function automatic logic [63:0] hdr_beat(input logic [15:0] id, input logic [2:0] status,
                                             input logic [1:0] fmt, input logic [9:0] len);
        return {id, status, 1'b0, 12'd4, 1'b0, fmt, 5'b01010, 14'd0, len};
    endfunction

    always_ff @(posedge pcieClk_in) begin
        if (push) mem[wr_ptr] <= '{req_id: req_reqID_in, tag: req_tag_in, addr: req_addr_in};
    end

    always_ff @(posedge pcieClk_in) begin
        if (pcieRst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge pcieClk_in) begin
        if (pcieRst_in) begin
            state        <= StIdle;
            hold         <= '0;
            data_q       <= '0;
            tx_data_out  <= '0;
            tx_valid_out <= 1'b0;
            tx_sop_out   <= 1'b0;
            tx_eop_out   <= 1'b0;
        end else begin
            case (state)
                StRead: state <= StLatch;
                StLatch: begin
                    data_q       <= regRdData_in;
                    state        <= StHdr;
                    tx_valid_out <= 1'b1;
                    tx_sop_out   <= 1'b1;
                    tx_eop_out   <= 1'b0;
                    tx_data_out  <= hdr_beat(cmpID_in, 3'b000, 2'b10, 10'd1);
                end
                StHdr: begin
                    if (tx_ready_in) begin
                        state       <= StData;
                        tx_sop_out  <= 1'b0;
                        tx_eop_out  <= 1'b1;
                        tx_data_out <= {data_q, hold.req_id, hold.tag, 1'b0, hold.addr[4:0], 2'b00};
                    end
                end
                StData: begin
                    if (tx_ready_in) begin
                        state        <= StIdle;
                        tx_valid_out <= 1'b0;
                        tx_sop_out   <= 1'b0;
                        tx_eop_out   <= 1'b0;
                        tx_data_out  <= '0;
                    end
                end
                default: state <= StIdle;
            endcase
            // A pop overrides the idle/return transition above.
            if (pop) begin
                hold <= head;
                if (head_ur) begin
                    state        <= StHdr;
                    data_q       <= '0;
                    tx_valid_out <= 1'b1;
                    tx_sop_out   <= 1'b1;
                    tx_eop_out   <= 1'b0;
                    tx_data_out  <= hdr_beat(cmpID_in, 3'b001, 2'b00, 10'd0);
                end else begin
                    state <= StRead;
                end
            end
        end
    end

endmodule

// File: tb/tb_tlp_cmp_gen.sv
// Directed self-checking bench for tlp_cmp_gen with a registered-read register file model.
module tb_tlp_cmp_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cmp_id = 16'h0200;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_id = '0;
    logic [7:0]  req_tag = '0;
    logic [29:0] req_addr = '0;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data = '0;
    logic [63:0] tx_data;
    logic        tx_valid, tx_ready = 1'b1, tx_sop, tx_eop;

    logic [31:0] regfile [32];
    int n_checks = 0;
    int n_pass = 0;

    localparam logic [63:0] HdrOk = 64'h0200_0004_4A00_0001;
    localparam logic [63:0] HdrUr = 64'h0200_2004_0A00_0000;

    tlp_cmp_gen dut (
        .pcieClk_in    (clk),
        .pcieRst_in    (rst),
        .cmpID_in      (cmp_id),
        .req_valid_in  (req_valid),
        .req_ready_out (req_ready),
        .req_reqID_in  (req_id),
        .req_tag_in    (req_tag),
        .req_addr_in   (req_addr),
        .regRdAddr_out (rd_addr),
        .regRdData_in  (rd_data),
        .tx_data_out   (tx_data),
        .tx_valid_out  (tx_valid),
        .tx_ready_in   (tx_ready),
        .tx_sop_out    (tx_sop),
        .tx_eop_out    (tx_eop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= regfile[rd_addr];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one request, wait for its header, then check both beats with tx_ready held high.
    task automatic run_cpl(input string name, input logic [7:0] tag, input logic [29:0] addr,
                           input logic [63:0] exp_hdr, input logic [63:0] exp_data);
        int n;
        req_id = 16'h0100; req_tag = tag; req_addr = addr; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!tx_valid && n < 20) begin
            tick();
            n++;
        end
        check({name, "_hdr_seen"}, 64'(tx_valid), 64'd1);
        check({name, "_hdr"}, tx_data, exp_hdr);
        tick();
        check({name, "_data"}, tx_data, exp_data);
        check({name, "_eop"}, 64'(tx_eop), 64'd1);
        tick();
    endtask

    initial begin
        int got;
        int vcnt;
        int n;
        for (int i = 0; i < 32; i++) regfile[i] = 32'h1000_0000 + 32'(i);
        regfile[3] = 32'hCAFE_BABE;

        // Reset state
        tick();
        tick();
        check("rst_valid", 64'(tx_valid), 64'd0);
        check("rst_data", tx_data, 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_rdaddr", 64'(rd_addr), 64'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 64'(req_ready), 64'd1);

        // Basic completion with exact latency
        req_id = 16'h0100; req_tag = 8'h05; req_addr = 30'h3; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("lat_n0_valid", 64'(tx_valid), 64'd0);
        tick();
        check("lat_read_addr", 64'(rd_addr), 64'd3);
        check("lat_read_valid", 64'(tx_valid), 64'd0);
        tick();
        check("lat_latch_valid", 64'(tx_valid), 64'd0);
        tick();
        check("lat_hdr_valid", 64'(tx_valid), 64'd1);
        check("lat_hdr_sop", 64'({tx_sop, tx_eop}), 64'b10);
        check("lat_hdr", tx_data, HdrOk);
        tick();
        check("lat_data", tx_data, 64'hCAFE_BABE_0100_050C);
        check("lat_data_eop", 64'({tx_sop, tx_eop}), 64'b01);
        tick();
        check("lat_idle_valid", 64'(tx_valid), 64'd0);

        // Backpressure on the header beat
        tx_ready = 1'b0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_hdr_hold", tx_data, HdrOk);
            tick();
        end
        tx_ready = 1'b1;
        check("bp_hdr_6th", tx_data, HdrOk);
        check("bp_hdr_sop", 64'({tx_valid, tx_sop}), 64'b11);
        tick();
        check("bp_data", tx_data, 64'hCAFE_BABE_0100_050C);
        tick();
        check("bp_after_valid", 64'(tx_valid), 64'd0);

        // Fill the queue while the sink stalls, then drain in order
        tx_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_tag = 8'(i);
            req_addr = 30'(i + 8);
            check("fill_ready", 64'(req_ready), 64'd1);
            tick();
        end
        req_valid = 1'b0;
        check("fill_full", 64'(req_ready), 64'd0);
        tx_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 80 && got < 5; c++) begin
            if (tx_valid && tx_eop) begin
                check("order_tag", 64'(tx_data[15:8]), 64'(got));
                check("order_rdata", 64'(tx_data[63:32]), 64'(32'h1000_0008 + 32'(got)));
                got++;
            end
            tick();
        end
        check("order_count", 64'(got), 64'd5);

        // Reset during the DATA beat with two requests queued
        tx_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_tag = 8'(7 + i);
            tick();
        end
        req_valid = 1'b0;
        n = 0;
        while (!tx_valid && n < 20) begin
            tick();
            n++;
        end
        check("mid_hdr_seen", 64'(tx_valid), 64'd1);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("mid_in_data", 64'({tx_valid, tx_eop}), 64'b11);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 64'(tx_valid), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;
        tx_ready = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_valid) vcnt++;
            tick();
        end
        check("mid_no_beats", 64'(vcnt), 64'd0);
        run_cpl("post_rst", 8'h2A, 30'h3, HdrOk, 64'hCAFE_BABE_0100_2A0C);

        // Address above the register file
`ifdef TLP_CMP_GEN_UR_EN
        run_cpl("ur", 8'h06, 30'h40, HdrUr, 64'h0000_0000_0100_0600);
`else
        run_cpl("alias", 8'h06, 30'h40, HdrOk, 64'h1000_0000_0100_0600);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
